// File: rtl/pixel_pkg.sv
// Shared definitions for the VGA output compositor.
//   - processing mode codes and their nominal pipeline latencies
//   - default latency table (entry m at [m*6 +: 6])
//   - mode-commit FSM state encoding
//   - idle value of the {hsync, vsync, blank} delay line
//   - RGB332 -> RGB888 expansion used by the BRAM readback path
package pixel_pkg;

    typedef enum logic [2:0] {
        MODE_NONE      = 3'd0,
        MODE_SEPIA     = 3'd1,
        MODE_INVERT    = 3'd2,
        MODE_GRAYSCALE = 3'd3,
        MODE_EDGE      = 3'd4,
        MODE_CARTOON   = 3'd5
    } mode_e;

    // Upstream filter pipeline depth for each mode, in pixel clocks.
    localparam int LAT_NONE      = 2;
    localparam int LAT_SEPIA     = 5;
    localparam int LAT_INVERT    = 3;
    localparam int LAT_GRAYSCALE = 6;
    localparam int LAT_EDGE      = 12;
    localparam int LAT_CARTOON   = 20;

    // Entries 6 and 7 are unused mode codes; they fall back to the bypass latency.
    localparam logic [47:0] DEFAULT_LAT_TABLE = {
        6'(LAT_NONE),      6'(LAT_NONE),      6'(LAT_CARTOON), 6'(LAT_EDGE),
        6'(LAT_GRAYSCALE), 6'(LAT_INVERT),    6'(LAT_SEPIA),   6'(LAT_NONE)
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_BLANKING = 2'd2
    } commit_state_e;

    // {hsync, vsync, blank} with all three de-asserted / blanking.
    localparam logic [2:0] SYNC_IDLE = 3'b111;

    function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] d);
        return {d[7:5], 5'b0, d[4:2], 5'b0, d[1:0], 6'b0};
    endfunction

endpackage

// File: rtl/pixel_compositor_if.sv
// Video stream bundle between the timing/filter pipeline and the compositor.
//   base_pixel  : filtered live pixel
//   layer_pixel : overlay pixels, layer i at [i*PIX_W +: PIX_W]
//   hcount/vcount, hsync/vsync/blank : raster position and timing (sync active-low)
//   pixel_out, hsync_out, vsync_out, blank_out : composited, latency-aligned output
// master = stream source / sink side, slave = compositor.
interface pixel_compositor_if #(
    parameter int PIX_W    = 24,
    parameter int N_LAYERS = 4
);
    logic [PIX_W-1:0]          base_pixel;
    logic [N_LAYERS*PIX_W-1:0] layer_pixel;
    logic [10:0]               hcount;
    logic [9:0]                vcount;
    logic                      hsync;
    logic                      vsync;
    logic                      blank;
    logic [PIX_W-1:0]          pixel_out;
    logic                      hsync_out;
    logic                      vsync_out;
    logic                      blank_out;

    modport master (
        output base_pixel, layer_pixel, hcount, vcount, hsync, vsync, blank,
        input  pixel_out, hsync_out, vsync_out, blank_out
    );

    modport slave (
        input  base_pixel, layer_pixel, hcount, vcount, hsync, vsync, blank,
        output pixel_out, hsync_out, vsync_out, blank_out
    );
endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a run-time selectable output tap.
//   clk, reset_n : pixel clock, async active-low reset (all stages load IDLE)
//   din          : WIDTH-bit word entering stage 0 every cycle
//   tap          : delay in cycles, 1..DEPTH (0 behaves as 1)
//   dout         : din delayed by tap cycles, taken straight from a flop
module sync_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 48,
    parameter logic [WIDTH-1:0] IDLE  = '1,
    parameter int               TAP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [TAP_W-1:0] tap_m1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= IDLE;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // stage[k] holds din from k+1 cycles ago.
    assign tap_m1 = (tap == '0) ? '0 : tap - 1'b1;
    assign dout   = stage[IDX_W'(tap_m1)];

endmodule

// File: rtl/pixel_compositor.sv
// Final-stage pixel compositor for the VGA output path.
// Merges the filtered base pixel with prioritised colour-keyed overlays, a border and
// an RGB332 BRAM readback path, and re-aligns hsync/vsync/blank to the latency of the
// currently committed processing mode. Mode changes take effect on a vsync falling
// edge, followed by a MAX_DLY-cycle blanking window while the delay line refills.
// Ports:
//   clk, reset_n   : pixel clock, async active-low reset (release synchronised upstream)
//   mode_sel       : requested processing mode
//   lat_table      : per-mode sync delay, entry m at [m*LAT_W +: LAT_W]
//   border_en      : draw a 2-px border around the active area
//   layer_en       : per-overlay enable, layer 0 highest priority
//   readback_en/valid/dout : show stored RGB332 frame instead of live video
//   force_black    : blank the video completely
//   vid            : video stream in/out (see pixel_compositor_if)
//   active_mode    : currently committed mode
//   switching      : high during the post-commit blanking window
//
// Mode commit FSM:
//   state       | meaning
//   ST_IDLE     | committed mode equals the requested mode
//   ST_PENDING  | different mode requested, waiting for the vsync falling edge
//   ST_BLANKING | mode just committed, blank_out held high for MAX_DLY cycles
module pixel_compositor
    import pixel_pkg::*;
#(
    parameter int               PIX_W      = 24,
    parameter int               N_LAYERS   = 4,
    parameter int               N_MODES    = 8,
    parameter int               LAT_W      = 6,
    parameter int               MAX_DLY    = 48,
    parameter logic [PIX_W-1:0] KEY_RGB    = 24'hFFFFFF,
    parameter int               H_ACTIVE   = 640,
    parameter int               V_ACTIVE   = 480,
    parameter logic [PIX_W-1:0] BORDER_RGB = 24'hFFFFFF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(N_MODES)-1:0] mode_sel,
    input  logic [N_MODES*LAT_W-1:0]   lat_table,
    input  logic                       border_en,
    input  logic [N_LAYERS-1:0]        layer_en,
    input  logic                       readback_en,
    input  logic                       readback_valid,
    input  logic [7:0]                 readback_dout,
    input  logic                       force_black,
    pixel_compositor_if.slave          vid,
    output logic [$clog2(N_MODES)-1:0] active_mode,
    output logic                       switching
);

    localparam int TAP_W = $clog2(MAX_DLY + 1);
    localparam int CNT_W = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    localparam logic [10:0] H_EDGE = 11'(H_ACTIVE - 2);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_EDGE = 10'(V_ACTIVE - 2);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] layer_arr [N_LAYERS];
    logic [PIX_W-1:0] pix_next;
    logic [PIX_W-1:0] pix_q;
    logic             on_border;

    always_comb begin
        for (int i = 0; i < N_LAYERS; i++) begin
            layer_arr[i] = vid.layer_pixel[i*PIX_W +: PIX_W];
        end
    end

    assign on_border = (vid.hcount < 11'd2)
                    || (vid.hcount >= H_EDGE && vid.hcount <= H_LAST)
                    || (vid.vcount < 10'd2)
                    || (vid.vcount >= V_EDGE && vid.vcount <= V_LAST);

    // Later assignments override earlier ones, so the sources are applied from
    // lowest to highest priority; the layer loop runs downwards so layer 0 wins.
    always_comb begin
        pix_next = vid.base_pixel;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && (layer_arr[i] != KEY_RGB)) begin
                pix_next = layer_arr[i];
            end
        end
        if (border_en && on_border) begin
            pix_next = BORDER_RGB;
        end
        if (readback_en) begin
            pix_next = readback_valid ? PIX_W'(rgb332_to_rgb888(readback_dout))
                                      : {PIX_W{1'b1}};
        end
        if (force_black) begin
            pix_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_next;
        end
    end

    assign vid.pixel_out = pix_q;

    // ------------------------------------------------------------------
    // Sync path
    // ------------------------------------------------------------------
    logic [LAT_W-1:0] lat_arr [N_MODES];
    logic [LAT_W-1:0] lat_entry;
    logic [TAP_W-1:0] tap;
    logic [2:0]       sync_dly;

    always_comb begin
        for (int m = 0; m < N_MODES; m++) begin
            lat_arr[m] = lat_table[m*LAT_W +: LAT_W];
        end
    end

    // A zero entry would select a non-existent stage; entries beyond the line
    // depth saturate at the last stage.
    always_comb begin
        lat_entry = lat_arr[active_mode];
        if (lat_entry == '0) begin
            tap = TAP_W'(1);
        end else if (32'(lat_entry) > MAX_DLY) begin
            tap = TAP_W'(MAX_DLY);
        end else begin
            tap = TAP_W'(lat_entry);
        end
    end

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (MAX_DLY),
        .IDLE  (SYNC_IDLE),
        .TAP_W (TAP_W)
    ) u_sync_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({vid.hsync, vid.vsync, vid.blank}),
        .tap     (tap),
        .dout    (sync_dly)
    );

    // The delay line contents straddle the old and new latency right after a
    // commit, so blank is held for a full line depth; h/v sync pass through.
    assign vid.hsync_out = sync_dly[2];
    assign vid.vsync_out = sync_dly[1];
    assign vid.blank_out = sync_dly[0] | switching;

    // ------------------------------------------------------------------
    // Mode commit FSM
    // ------------------------------------------------------------------
    commit_state_e    state;
    logic [CNT_W-1:0] blank_cnt;
    logic             vsync_q;
    logic             vsync_fall;

    assign vsync_fall = vsync_q & ~vid.vsync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            active_mode <= '0;
            switching   <= 1'b0;
            blank_cnt   <= '0;
            vsync_q     <= 1'b1;
        end else begin
            vsync_q <= vid.vsync;
            case (state)
                ST_IDLE: begin
                    if (mode_sel != active_mode) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (mode_sel == active_mode) begin
                        state <= ST_IDLE;
                    end else if (vsync_fall) begin
                        active_mode <= mode_sel;
                        blank_cnt   <= CNT_W'(MAX_DLY - 1);
                        switching   <= 1'b1;
                        state       <= ST_BLANKING;
                    end
                end
                ST_BLANKING: begin
                    if (blank_cnt == '0) begin
                        switching <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
module tb_pixel_compositor;
    import pixel_pkg::*;

    localparam int PIX_W    = 24;
    localparam int N_LAYERS = 4;
    localparam int N_MODES  = 8;
    localparam int LAT_W    = 6;
    localparam int MAX_DLY  = 48;

    localparam int H_PICK [7] = '{0, 1, 2, 637, 638, 639, 640};
    localparam int V_PICK [7] = '{0, 1, 2, 477, 478, 479, 480};

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [2:0]                 mode_sel;
    logic [N_MODES*LAT_W-1:0]   lat_table;
    logic                       border_en;
    logic [N_LAYERS-1:0]        layer_en;
    logic                       readback_en;
    logic                       readback_valid;
    logic [7:0]                 readback_dout;
    logic                       force_black;
    logic [2:0]                 active_mode;
    logic                       switching;

    pixel_compositor_if #(.PIX_W(PIX_W), .N_LAYERS(N_LAYERS)) vif ();

    pixel_compositor #(
        .PIX_W(PIX_W), .N_LAYERS(N_LAYERS), .N_MODES(N_MODES), .LAT_W(LAT_W),
        .MAX_DLY(MAX_DLY), .KEY_RGB(24'hFFFFFF), .H_ACTIVE(640), .V_ACTIVE(480),
        .BORDER_RGB(24'hFFFFFF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mode_sel       (mode_sel),
        .lat_table      (lat_table),
        .border_en      (border_en),
        .layer_en       (layer_en),
        .readback_en    (readback_en),
        .readback_valid (readback_valid),
        .readback_dout  (readback_dout),
        .force_black    (force_black),
        .vid            (vif),
        .active_mode    (active_mode),
        .switching      (switching)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_mode;
    bit         m_pend;
    int         m_blank_left;
    bit         m_vs_prev;
    logic [2:0] m_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_pend       = 1'b0;
        m_blank_left = 0;
        m_vs_prev    = 1'b1;
        m_hist.delete();
    endtask

    function automatic int tap_for(int mode);
        int lat;
        lat = int'((lat_table >> (mode * LAT_W)) & 48'h3F);
        if (lat == 0) return 1;
        if (lat > MAX_DLY) return MAX_DLY;
        return lat;
    endfunction

    function automatic logic [23:0] ref_pixel();
        int hc, vc, d;
        logic [23:0] lp;
        hc = int'(vif.hcount);
        vc = int'(vif.vcount);
        d  = int'(readback_dout);
        if (force_black) return 24'h0;
        if (readback_en) begin
            if (!readback_valid) return 24'hFFFFFF;
            return 24'((((d >> 5) & 7) << 21) | (((d >> 2) & 7) << 13) | ((d & 3) << 6));
        end
        if (border_en && (hc < 2 || (hc >= 638 && hc <= 639) || vc < 2 || (vc >= 478 && vc <= 479)))
            return 24'hFFFFFF;
        for (int i = 0; i < N_LAYERS; i++) begin
            lp = vif.layer_pixel[i*PIX_W +: PIX_W];
            if (layer_en[i] && lp != 24'hFFFFFF) return lp;
        end
        return vif.base_pixel;
    endfunction

    task automatic check_reset_vals();
        chk("rst_pix",   32'(vif.pixel_out), 32'h0);
        chk("rst_hsync", 32'(vif.hsync_out), 32'h1);
        chk("rst_vsync", 32'(vif.vsync_out), 32'h1);
        chk("rst_blank", 32'(vif.blank_out), 32'h1);
        chk("rst_mode",  32'(active_mode),   32'h0);
        chk("rst_sw",    32'(switching),     32'h0);
    endtask

    // Advance one clock; inputs currently driven are what the DUT samples.
    task automatic step();
        logic [23:0] exp_pix;
        logic [2:0]  exp_sync;
        int          tap;
        bit          vs_fall;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
            check_reset_vals();
            return;
        end
        exp_pix   = ref_pixel();
        vs_fall   = m_vs_prev && !vif.vsync;
        m_vs_prev = vif.vsync;
        if (m_blank_left > 0) begin
            m_blank_left--;
        end else if (!m_pend) begin
            m_pend = (int'(mode_sel) != m_mode);
        end else if (int'(mode_sel) == m_mode) begin
            m_pend = 1'b0;
        end else if (vs_fall) begin
            m_mode       = int'(mode_sel);
            m_pend       = 1'b0;
            m_blank_left = MAX_DLY;
        end
        m_hist.push_front({vif.hsync, vif.vsync, vif.blank});
        if (m_hist.size() > MAX_DLY) void'(m_hist.pop_back());
        tap      = tap_for(m_mode);
        exp_sync = (tap <= m_hist.size()) ? m_hist[tap-1] : 3'b111;
        chk("pixel", 32'(vif.pixel_out), 32'(exp_pix));
        chk("hsync", 32'(vif.hsync_out), 32'(exp_sync[2]));
        chk("vsync", 32'(vif.vsync_out), 32'(exp_sync[1]));
        chk("blank", 32'(vif.blank_out), 32'(exp_sync[0] | (m_blank_left > 0)));
        chk("mode",  32'(active_mode),   32'(m_mode));
        chk("sw",    32'(switching),     32'(m_blank_left > 0));
    endtask

    task automatic set_lat(input int m, input int v);
        lat_table[m*LAT_W +: LAT_W] = 6'(v);
    endtask

    task automatic drive_random(input bit allow_mode);
        vif.hcount = ($urandom_range(0, 2) == 0) ? 11'(H_PICK[$urandom_range(0, 6)])
                                                 : 11'($urandom_range(0, 799));
        vif.vcount = ($urandom_range(0, 2) == 0) ? 10'(V_PICK[$urandom_range(0, 6)])
                                                 : 10'($urandom_range(0, 524));
        vif.base_pixel = 24'($urandom);
        for (int i = 0; i < N_LAYERS; i++) begin
            vif.layer_pixel[i*PIX_W +: PIX_W] = ($urandom_range(0, 2) == 0) ? 24'hFFFFFF
                                                                             : 24'($urandom);
        end
        layer_en       = 4'($urandom);
        border_en      = 1'($urandom_range(0, 1));
        force_black    = ($urandom_range(0, 15) == 0);
        readback_en    = ($urandom_range(0, 7) == 0);
        readback_valid = 1'($urandom_range(0, 1));
        readback_dout  = 8'($urandom);
        if ($urandom_range(0, 5) == 0)  vif.hsync = ~vif.hsync;
        if ($urandom_range(0, 3) == 0)  vif.blank = ~vif.blank;
        if ($urandom_range(0, 59) == 0) vif.vsync = ~vif.vsync;
        if (allow_mode && $urandom_range(0, 149) == 0) mode_sel = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int sw_cnt;

        reset_n         = 1'b1;
        mode_sel        = 3'd0;
        lat_table       = DEFAULT_LAT_TABLE;
        border_en       = 1'b0;
        layer_en        = '0;
        readback_en     = 1'b0;
        readback_valid  = 1'b0;
        readback_dout   = '0;
        force_black     = 1'b0;
        vif.base_pixel  = '0;
        vif.layer_pixel = '0;
        vif.hcount      = 11'd100;
        vif.vcount      = 10'd100;
        vif.hsync       = 1'b1;
        vif.vsync       = 1'b1;
        vif.blank       = 1'b1;
        model_reset();

        #2 reset_n = 1'b0;
        #1 check_reset_vals();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();

        // Overlay priority with a keyed layer in front.
        layer_en = 4'b0110;
        vif.layer_pixel = {24'h0000FF, 24'h00FF00, 24'hFFFFFF, 24'hFF0000};
        vif.base_pixel  = 24'h123456;
        step();
        chk("layer_pri", 32'(vif.pixel_out), 32'h00FF00);
        layer_en = 4'b0000;
        step();
        chk("layer_off", 32'(vif.pixel_out), 32'h123456);

        // Readback expansion, invalid region, force_black override.
        readback_en = 1'b1; readback_dout = 8'b101_010_11; readback_valid = 1'b1;
        step();
        chk("rb_valid", 32'(vif.pixel_out), 32'hA040C0);
        readback_valid = 1'b0;
        step();
        chk("rb_invalid", 32'(vif.pixel_out), 32'hFFFFFF);
        force_black = 1'b1;
        step();
        chk("force_black", 32'(vif.pixel_out), 32'h000000);
        force_black = 1'b0; readback_en = 1'b0;

        // Border edges.
        border_en = 1'b1; vif.hcount = 11'd639;
        step();
        chk("border_h639", 32'(vif.pixel_out), 32'hFFFFFF);
        vif.hcount = 11'd640; vif.vcount = 10'd477;
        step();
        chk("border_off", 32'(vif.pixel_out), 32'h123456);
        border_en = 1'b0;

        // Sync delay: entry 7, entry 0 -> 1, entry 63 -> MAX_DLY.
        set_lat(0, 7);
        repeat (50) step();
        for (int k = 0; k < 12; k++) begin
            vif.hsync = (k < 2) ? 1'b0 : 1'b1;
            step();
            chk("dly7", 32'(vif.hsync_out), (k == 6 || k == 7) ? 32'h0 : 32'h1);
        end
        set_lat(0, 0);
        for (int k = 0; k < 5; k++) begin
            vif.hsync = (k == 0) ? 1'b0 : 1'b1;
            step();
            chk("dly1", 32'(vif.hsync_out), (k == 0) ? 32'h0 : 32'h1);
        end
        set_lat(0, 63);
        repeat (50) step();
        for (int k = 0; k < 51; k++) begin
            vif.hsync = (k == 0) ? 1'b0 : 1'b1;
            step();
            chk("dly48", 32'(vif.hsync_out), (k == 47) ? 32'h0 : 32'h1);
        end
        set_lat(0, 5);
        repeat (60) begin
            drive_random(1'b0);
            step();
        end

        // Mode commit at vsync fall.
        set_lat(3, 12);
        vif.vsync = 1'b1;
        repeat (3) step();
        mode_sel = 3'd3;
        repeat (20) begin
            drive_random(1'b0);
            vif.vsync = 1'b1;
            step();
        end
        chk("mode_hold", 32'(active_mode), 32'h0);
        vif.vsync = 1'b0;
        step();
        chk("mode_commit", 32'(active_mode), 32'h3);
        chk("sw_start", 32'(switching), 32'h1);
        sw_cnt = 1;
        for (int k = 0; k < 60; k++) begin
            drive_random(1'b0);
            vif.vsync = 1'b0;
            step();
            if (switching) begin
                sw_cnt++;
                chk("blank_forced", 32'(vif.blank_out), 32'h1);
            end
        end
        chk("sw_len", 32'(sw_cnt), 32'(MAX_DLY));

        // Request withdrawn before vsync: no commit.
        vif.vsync = 1'b1;
        repeat (3) step();
        mode_sel = 3'd5;
        repeat (5) step();
        mode_sel = 3'd3;
        repeat (5) step();
        vif.vsync = 1'b0;
        repeat (5) step();
        chk("no_commit_mode", 32'(active_mode), 32'h3);
        chk("no_commit_sw", 32'(switching), 32'h0);

        // Randomised run with an asynchronous reset in the middle.
        for (int m = 0; m < N_MODES; m++) set_lat(m, $urandom_range(0, 63));
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2 reset_n = 1'b0;
                #1 check_reset_vals();
                model_reset();
                repeat (3) step();
                reset_n = 1'b1;
            end
            drive_random(1'b1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
